// File: rtl/selftrigger_pkg.sv
// Shared types and defaults for the self-trigger scheduler: phase enum,
// channel-index width helper and default phase/holdoff lengths.
package selftrigger_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_e;

    localparam int FLUSH_LEN_DEF  = 16;
    localparam int SETTLE_LEN_DEF = 512;
    localparam int HOLDOFF_DEF    = 256;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/selftrigger_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr_i,
// wrapping past NCH-1 back to 0.
module selftrigger_rr_arbiter
    import selftrigger_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int CH_W = ch_w(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic            gnt_valid_o,
    output logic [CH_W-1:0] gnt_idx_o
);

    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_rot;

    // Rotating a doubled copy puts ptr_i at bit 0, so bit j is channel ptr_i+j.
    assign req_dbl = {req_i, req_i};
    assign req_rot = NCH'(req_dbl >> ptr_i);

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] p, input int j);
        logic [CH_W:0] sum;
        sum = {1'b0, p} + (CH_W+1)'(j);
        if (sum >= (CH_W+1)'(NCH)) begin
            sum = sum - (CH_W+1)'(NCH);
        end
        return sum[CH_W-1:0];
    endfunction

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = wrap_add(ptr_i, j);
            end
        end
    end

endmodule

// File: rtl/selftrigger_scheduler.sv
// Sequences the self-trigger filters (flush, settle, run), timestamps trigger
// edges, applies per-channel holdoff and serialises events onto valid/ready.
module selftrigger_scheduler
    import selftrigger_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int TS_W       = 32,
    parameter int FLUSH_LEN  = FLUSH_LEN_DEF,
    parameter int SETTLE_LEN = SETTLE_LEN_DEF,
    parameter int HOLDOFF    = HOLDOFF_DEF,
    parameter int CH_W       = ch_w(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [NCH-1:0]  trig_in,
    output logic            filt_enable,
    output logic            filt_flush,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CH_W-1:0] ev_channel,
    output logic [TS_W-1:0] ev_timestamp,
    output logic [15:0]     lost_count,
    output logic            busy
);

    localparam int CNT_MAX = (FLUSH_LEN > SETTLE_LEN) ? FLUSH_LEN : SETTLE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HO_W    = $clog2(HOLDOFF + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [NCH-1:0]    trig_q, trig_prev_q, trig_rise;
    logic [NCH-1:0]    pending_q, pending_d, accept;
    logic [TS_W-1:0]   ts_arr_q [NCH];
    logic [TS_W-1:0]   ts_arr_d [NCH];
    logic [HO_W-1:0]   holdoff_q [NCH];
    logic [HO_W-1:0]   holdoff_d [NCH];
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]       lost_q, lost_d;
    logic [4:0]        n_lost;
    logic [16:0]       lost_sum;
    logic              ev_valid_q;
    logic [CH_W-1:0]   ev_channel_q;
    logic [TS_W-1:0]   ev_ts_q;
    logic              stop, grant, gnt_valid;
    logic [CH_W-1:0]   gnt_idx;

    assign stop      = !run && (state_q != IDLE);
    assign trig_rise = trig_q & ~trig_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q + TS_W'(1);
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    ts_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_LEN - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    selftrigger_rr_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
        .req_i       (pending_q & ch_mask),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign grant = (state_q == RUN) && run && gnt_valid && (!ev_valid_q || ev_ready);

    // The channel being granted this cycle is about to enter holdoff, so its edge is dropped.
    always_comb begin
        accept = '0;
        for (int c = 0; c < NCH; c++) begin
            accept[c] = trig_rise[c] && ch_mask[c] && (holdoff_q[c] == '0) &&
                        (state_q == RUN) && !(grant && (gnt_idx == CH_W'(c)));
        end
    end

    always_comb begin
        pending_d = pending_q;
        ts_arr_d  = ts_arr_q;
        rr_ptr_d  = rr_ptr_q;
        n_lost    = '0;
        for (int c = 0; c < NCH; c++) begin
            holdoff_d[c] = (holdoff_q[c] != '0) ? holdoff_q[c] - 1'b1 : '0;
        end
        if (grant) begin
            pending_d[gnt_idx] = 1'b0;
            holdoff_d[gnt_idx] = HO_W'(HOLDOFF);
            rr_ptr_d = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (accept[c]) begin
                if (pending_q[c]) begin
                    n_lost = n_lost + 5'd1;
                end else begin
                    pending_d[c] = 1'b1;
                    ts_arr_d[c]  = ts_q;
                end
            end
        end
        pending_d = pending_d & ch_mask;
        if (stop) begin
            pending_d = '0;
            for (int c = 0; c < NCH; c++) begin
                holdoff_d[c] = '0;
            end
        end
        lost_sum = {1'b0, lost_q} + 17'(n_lost);
        lost_d   = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ts_q         <= '0;
            trig_q       <= '0;
            trig_prev_q  <= '0;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            lost_q       <= '0;
            ev_valid_q   <= 1'b0;
            ev_channel_q <= '0;
            ev_ts_q      <= '0;
            for (int c = 0; c < NCH; c++) begin
                ts_arr_q[c]  <= '0;
                holdoff_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ts_q        <= ts_d;
            trig_q      <= trig_in;
            trig_prev_q <= trig_q;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            lost_q      <= lost_d;
            ts_arr_q    <= ts_arr_d;
            holdoff_q   <= holdoff_d;
            if (grant) begin
                ev_valid_q   <= 1'b1;
                ev_channel_q <= gnt_idx;
                ev_ts_q      <= ts_arr_q[gnt_idx];
            end else if (ev_ready) begin
                ev_valid_q <= 1'b0;
            end
        end
    end

    assign filt_enable  = (state_q == SETTLE) || (state_q == RUN);
    assign filt_flush   = (state_q == FLUSH);
    assign busy         = (state_q != IDLE);
    assign ev_valid     = ev_valid_q;
    assign ev_channel   = ev_channel_q;
    assign ev_timestamp = ev_ts_q;
    assign lost_count   = lost_q;

endmodule
